// File: rtl/vga_glyph_gen.sv
// Text-mode glyph renderer: 4-stage pipeline (cell address -> tile RAM -> font ROM -> colour).
// Define VGA_GLYPH_CURSOR_EN to add the blinking cursor (fg/bg swap on the cursor cell).
module vga_glyph_gen #(
    parameter int COLS      = 80,
    parameter int ROWS      = 30,
    parameter int GLYPH_W   = 8,
    parameter int GLYPH_H   = 16,
    parameter int BLINK_DIV = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         pixelEn,
    input  logic                         bright,
    input  logic                         hsyncIn,
    input  logic                         vsyncIn,
    input  logic [9:0]                   hCount,
    input  logic [9:0]                   vCount,
    input  logic                         slowPulse,
    input  logic [7:0]                   cursorCol,
    input  logic [7:0]                   cursorRow,
    output logic [15:0]                  tileAddr,
    input  logic [15:0]                  tileData,
    output logic [8+$clog2(GLYPH_H)-1:0] fontAddr,
    input  logic [GLYPH_W-1:0]           fontData,
    output logic [7:0]                   rgb,
    output logic                         hsyncOut,
    output logic                         vsyncOut
);
    localparam int          GW_L    = $clog2(GLYPH_W);
    localparam int          GH_L    = $clog2(GLYPH_H);
    localparam logic [10:0] TEXT_W  = 11'(COLS * GLYPH_W);
    localparam logic [10:0] TEXT_H  = 11'(ROWS * GLYPH_H);
    localparam logic [15:0] COLS_16 = 16'(COLS);

    function automatic logic [7:0] expand(input logic [2:0] c);
        return {{3{c[2]}}, {3{c[1]}}, {2{c[0]}}};
    endfunction

    logic [9:0]            cellCol, cellRow;
    logic                  inText;
    logic [15:0]           tileAddr_d, tileAddr_q;
    logic [GH_L-1:0]       glyphRow_s1_q;
    logic [GW_L-1:0]       pixCol_s1_q, pixCol_s2_q;
    logic [8+GH_L-1:0]     fontAddr_d, fontAddr_q;
    logic [2:0]            fg_s2_q, bg_s2_q, fg_s3_q, bg_s3_q;
    logic                  pixel_s3_q;
    logic [2:0]            fgSel, bgSel;
    logic [7:0]            rgb_d, rgb_q;
    logic [3:0]            bright_q, inText_q, hsync_q, vsync_q;
    logic                  swap;
    logic                  unused_bits;

    assign cellCol    = hCount >> GW_L;
    assign cellRow    = vCount >> GH_L;
    assign inText     = ({1'b0, hCount} < TEXT_W) && ({1'b0, vCount} < TEXT_H);
    assign tileAddr_d = COLS_16 * {6'd0, cellRow} + {6'd0, cellCol};
    assign fontAddr_d = {tileData[7:0], glyphRow_s1_q};

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tileAddr_q    <= '0;
            glyphRow_s1_q <= '0;
            pixCol_s1_q   <= '0;
            fontAddr_q    <= '0;
            fg_s2_q       <= '0;
            bg_s2_q       <= '0;
            pixCol_s2_q   <= '0;
            pixel_s3_q    <= 1'b0;
            fg_s3_q       <= '0;
            bg_s3_q       <= '0;
            rgb_q         <= '0;
            bright_q      <= '0;
            inText_q      <= '0;
            hsync_q       <= '0;
            vsync_q       <= '0;
        end else if (pixelEn) begin
            // Stage 1: cell address and intra-glyph coordinates
            tileAddr_q    <= tileAddr_d;
            glyphRow_s1_q <= vCount[GH_L-1:0];
            pixCol_s1_q   <= hCount[GW_L-1:0];
            // Stage 2: tile word -> font address and colours
            fontAddr_q    <= fontAddr_d;
            fg_s2_q       <= tileData[15:13];
            bg_s2_q       <= tileData[12:10];
            pixCol_s2_q   <= pixCol_s1_q;
            // Stage 3: pick the pixel bit; ~col == GLYPH_W-1-col since GLYPH_W is a power of two
            pixel_s3_q    <= fontData[~pixCol_s2_q];
            fg_s3_q       <= fg_s2_q;
            bg_s3_q       <= bg_s2_q;
            // Stage 4: colour out, control delay line advances with the data
            rgb_q         <= rgb_d;
            bright_q      <= {bright_q[2:0], bright};
            inText_q      <= {inText_q[2:0], inText};
            hsync_q       <= {hsync_q[2:0], hsyncIn};
            vsync_q       <= {vsync_q[2:0], vsyncIn};
        end
    end

`ifdef VGA_GLYPH_CURSOR_EN
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BC_W-1:0] blinkCnt_q;
    logic            blinkOn_q;
    logic [9:0]      cellCol_s1_q, cellCol_s2_q, cellCol_s3_q;
    logic [9:0]      cellRow_s1_q, cellRow_s2_q, cellRow_s3_q;

    // Blink timing runs off slowPulse alone; only the cell tags follow pixelEn.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            blinkCnt_q   <= '0;
            blinkOn_q    <= 1'b0;
            cellCol_s1_q <= '0;
            cellCol_s2_q <= '0;
            cellCol_s3_q <= '0;
            cellRow_s1_q <= '0;
            cellRow_s2_q <= '0;
            cellRow_s3_q <= '0;
        end else begin
            if (slowPulse) begin
                if (blinkCnt_q == BC_W'(BLINK_DIV - 1)) begin
                    blinkCnt_q <= '0;
                    blinkOn_q  <= ~blinkOn_q;
                end else begin
                    blinkCnt_q <= blinkCnt_q + 1'b1;
                end
            end
            if (pixelEn) begin
                cellCol_s1_q <= cellCol;
                cellCol_s2_q <= cellCol_s1_q;
                cellCol_s3_q <= cellCol_s2_q;
                cellRow_s1_q <= cellRow;
                cellRow_s2_q <= cellRow_s1_q;
                cellRow_s3_q <= cellRow_s2_q;
            end
        end
    end

    assign swap = blinkOn_q && (cellCol_s3_q == {2'b00, cursorCol})
                            && (cellRow_s3_q == {2'b00, cursorRow});
    assign unused_bits = ^{tileData[9:8], bright_q[3], inText_q[3]};
`else
    assign swap = 1'b0;
    assign unused_bits = ^{tileData[9:8], bright_q[3], inText_q[3], slowPulse,
                           cursorCol, cursorRow, 32'(BLINK_DIV)};
`endif

    always_comb begin
        fgSel = fg_s3_q;
        bgSel = bg_s3_q;
        if (swap) begin
            fgSel = bg_s3_q;
            bgSel = fg_s3_q;
        end
        rgb_d = 8'h00;
        if (bright_q[2] && inText_q[2]) begin
            rgb_d = expand(pixel_s3_q ? fgSel : bgSel);
        end
    end

    assign tileAddr = tileAddr_q;
    assign fontAddr = fontAddr_q;
    assign rgb      = rgb_q;
    assign hsyncOut = hsync_q[3];
    assign vsyncOut = vsync_q[3];
endmodule

// File: doc/vga_glyph_gen.md
VGA_GLYPH_GEN -- requirements
Module: vga_glyph_gen

Interface
REQ-001 Parameter COLS, default 80: text columns.
REQ-002 Parameter ROWS, default 30: text rows.
REQ-003 Parameter GLYPH_W, default 8: glyph width in pixels (power of two).
REQ-004 Parameter GLYPH_H, default 16: glyph height in pixels (power of two).
REQ-005 Parameter BLINK_DIV, default 8: slowPulse strobes per cursor blink-phase toggle.
REQ-006 clock  in  1  single system clock; all logic on rising edge.
REQ-007 reset_n  in  1  asynchronous, active-low reset.
REQ-008 pixelEn  in  1  pixel-rate enable; the pipeline advances only on cycles with pixelEn=1.
REQ-009 bright  in  1  active-video flag aligned with hCount/vCount.
REQ-010 hsyncIn, vsyncIn  in  1 each  sync from the timing generator, aligned with hCount.
REQ-011 hCount, vCount  in  10 each  current pixel coordinates.
REQ-012 slowPulse  in  1  single-cycle blink-time strobe.
REQ-013 cursorCol, cursorRow  in  8 each  cursor cell position.
REQ-014 tileAddr  out  16  text-RAM read address, row*COLS+col.
REQ-015 tileData  in  16  {fg[2:0], bg[2:0], 2'b unused, charCode[7:0]}, one cycle after tileAddr.
REQ-016 fontAddr  out  8+log2(GLYPH_H)  {charCode, glyphRow} font-ROM address.
REQ-017 fontData  in  GLYPH_W  glyph row bits, one cycle after fontAddr; MSB is leftmost pixel.
REQ-018 rgb  out  8  pixel colour, RRRGGGBB.
REQ-019 hsyncOut, vsyncOut  out  1 each  sync delayed to match rgb.

Function
REQ-020 Stage 1 (pixelEn edge k): register tileAddr, glyphRow=vCount mod GLYPH_H, pixel column=hCount mod GLYPH_W, and an inText flag (hCount<COLS*GLYPH_W and vCount<ROWS*GLYPH_H).
REQ-021 Stage 2 (edge k+1): capture tileData; register fontAddr={charCode, glyphRow}, fg, bg.
REQ-022 Stage 3 (edge k+2): capture fontData; select bit GLYPH_W-1-pixelColumn.
REQ-023 Stage 4 (edge k+3): register rgb; total latency exactly 4 pixelEn cycles from hCount to rgb.
REQ-024 bright, inText, hsyncIn and vsyncIn are carried in a 4-deep shift register; hsyncOut/vsyncOut equal hsyncIn/vsyncIn delayed exactly 4 pixelEn cycles.
REQ-025 Colour expansion: a 3-bit colour {r,g,b} maps to rgb={3{r},3{g},2{b}}.
REQ-026 rgb = expand(fg) when selected bit=1, expand(bg) when 0, and 8'h00 whenever delayed bright=0 or delayed inText=0.
REQ-027 Coordinates on the last text pixel (hCount=COLS*GLYPH_W-1) render normally; hCount=COLS*GLYPH_W renders 8'h00.
REQ-028 With pixelEn=0 every register, including tileAddr/fontAddr, holds; the external memories tolerate repeated reads.
REQ-029 Divisions and modulos by GLYPH_W/GLYPH_H are bit slices; row*COLS is an unsigned 16-bit product, truncated.

Reset
REQ-030 reset_n=0 forces rgb=8'h00, hsyncOut=vsyncOut=0, tileAddr=0, fontAddr=0, all delay stages and blink state to 0, immediately and without a clock.
REQ-031 After reset_n rises, rgb remains 8'h00 until four pixelEn cycles have refilled the pipeline; reset mid-frame requires no resynchronisation beyond this.

Configuration
REQ-032 Macro VGA_GLYPH_CURSOR_EN defined: a counter counts slowPulse strobes 0..BLINK_DIV-1 and on wrap toggles blinkOn; while blinkOn=1 and the stage-4 cell equals (cursorCol, cursorRow), fg and bg are swapped.
REQ-033 slowPulse coinciding with pixelEn=0 is still counted; counter and blinkOn ignore pixelEn.
REQ-034 Macro undefined: counter and blinkOn are absent, cursor ports and slowPulse are ignored, and no swap ever occurs; port list is unchanged.

Verification
REQ-035 Reset, then 4 pixelEn pulses with bright=1, tileData=16'hE041 ('A', fg=7, bg=0), fontData=8'h80, hCount=0 -> rgb=8'hFF on the 4th pulse; rgb=8'h00 before it.
REQ-036 Same stimulus with hCount=1 -> rgb=8'h00 (bg black); with bg=3'b001 -> rgb=8'h03.
REQ-037 hCount=640, vCount=0, bright=1, fontData=8'hFF -> rgb=8'h00; hsyncIn pulse -> hsyncOut pulse exactly 4 pixelEn cycles later.
REQ-038 pixelEn toggling 1,0,0,1 -> outputs frozen during 0-cycles; latency counted in pixelEn cycles only.
REQ-039 VGA_GLYPH_CURSOR_EN, BLINK_DIV=2, cursor (0,0), fg=7, bg=0, fontData=8'h80 -> rgb=8'hFF; after 2 slowPulse strobes -> rgb=8'h00; after 2 more -> 8'hFF; macro undefined -> always 8'hFF.
REQ-040 Assert reset_n=0 mid-line -> rgb=8'h00 and hsyncOut=0 within the same cycle, no clock edge required.
